// File: rtl/cpu_defs.sv
// Shared constants for the MIPS pipeline stages.
package cpu_defs;

  localparam logic [31:0] NOP_INSTR          = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC   = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_EXC_VECTOR = 32'h0000_0080;
  localparam logic [31:0] PC_INCREMENT       = 32'd4;

endpackage

// File: rtl/if_id_register.sv
// Generic pipeline register holding instruction, pc_plus4 and valid, with
// stall (hold) and flush (bubble) controls; flush wins over stall.
module if_id_register
  import cpu_defs::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] fetch_instruction,
  input  logic [31:0] fetch_pc_plus4,
  input  logic        fetch_valid,
  output logic [31:0] instruction,
  output logic [31:0] pc_plus4,
  output logic        valid
);

  // A bubble is a nop with a cleared valid bit, so later stages ignore it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      instruction <= NOP_INSTR;
      pc_plus4    <= 32'h0;
      valid       <= 1'b0;
    end else if (flush) begin
      instruction <= NOP_INSTR;
      pc_plus4    <= 32'h0;
      valid       <= 1'b0;
    end else if (!stall) begin
      instruction <= fetch_instruction;
      pc_plus4    <= fetch_pc_plus4;
      valid       <= fetch_valid;
    end
  end

endmodule

// File: rtl/instruction_fetch_stage.sv
// IF stage: owns the PC, addresses instruction memory, fills IF/ID and
// counts delivered instructions.
module instruction_fetch_stage
  import cpu_defs::*;
#(
  parameter int          RAM_SIZE_BIT = 8,
  parameter logic [31:0] RESET_PC     = DEFAULT_RESET_PC,
  parameter logic [31:0] EXC_VECTOR   = DEFAULT_EXC_VECTOR
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    stall,
  input  logic                    flush,
  input  logic                    exception,
  input  logic                    branch_taken,
  input  logic [31:0]             branch_target,
  input  logic                    jump,
  input  logic [31:0]             jump_target,
  output logic [RAM_SIZE_BIT-1:0] imem_address,
  input  logic [31:0]             imem_read_data,
  output logic [31:0]             pc,
  output logic [31:0]             if_id_instruction,
  output logic [31:0]             if_id_pc_plus4,
  output logic                    if_id_valid,
  output logic [31:0]             fetch_count
);

  logic        redirect;
  logic [31:0] redirect_target;
  logic [31:0] pc_plus4;
  logic [31:0] next_pc;
  logic        bubble;

  assign pc_plus4     = pc + PC_INCREMENT;
  assign imem_address = pc[RAM_SIZE_BIT+1:2];
  assign bubble       = redirect | flush;

  // Redirects beat stall so a taken control transfer is never delayed.
  always_comb begin
    redirect        = exception | branch_taken | jump;
    redirect_target = jump_target;
    if (exception)
      redirect_target = EXC_VECTOR;
    else if (branch_taken)
      redirect_target = branch_target;

    if (redirect)
      next_pc = redirect_target & 32'hFFFF_FFFC;
    else if (stall)
      next_pc = pc;
    else
      next_pc = pc_plus4;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      pc <= RESET_PC;
    else
      pc <= next_pc;
  end

  // Counts exactly the cycles where IF/ID takes a real instruction.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      fetch_count <= 32'h0;
    else if (!bubble && !stall)
      fetch_count <= fetch_count + 32'd1;
  end

  if_id_register u_if_id_register (
    .clk               (clk),
    .reset_n           (reset_n),
    .stall             (stall),
    .flush             (bubble),
    .fetch_instruction (imem_read_data),
    .fetch_pc_plus4    (pc_plus4),
    .fetch_valid       (1'b1),
    .instruction       (if_id_instruction),
    .pc_plus4          (if_id_pc_plus4),
    .valid             (if_id_valid)
  );

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Directed bench for instruction_fetch_stage with a combinational memory
// model whose word i holds 32'hA000_0000 + i.
module tb_instruction_fetch_stage;

  logic        clk;
  logic        reset_n;
  logic        stall;
  logic        flush;
  logic        exception;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic [7:0]  imem_address;
  logic [31:0] imem_read_data;
  logic [31:0] pc;
  logic [31:0] if_id_instruction;
  logic [31:0] if_id_pc_plus4;
  logic        if_id_valid;
  logic [31:0] fetch_count;

  logic [31:0] mem [256];
  int          error_count;
  int          check_count;

  instruction_fetch_stage #(
    .RAM_SIZE_BIT (8),
    .RESET_PC     (32'h0000_0000),
    .EXC_VECTOR   (32'h0000_0080)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .stall             (stall),
    .flush             (flush),
    .exception         (exception),
    .branch_taken      (branch_taken),
    .branch_target     (branch_target),
    .jump              (jump),
    .jump_target       (jump_target),
    .imem_address      (imem_address),
    .imem_read_data    (imem_read_data),
    .pc                (pc),
    .if_id_instruction (if_id_instruction),
    .if_id_pc_plus4    (if_id_pc_plus4),
    .if_id_valid       (if_id_valid),
    .fetch_count       (fetch_count)
  );

  assign imem_read_data = mem[imem_address];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word(input int i);
    return 32'hA000_0000 + i;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  // Sets the control inputs, then lets one posedge consume them.
  task automatic applyStimulus(input logic s, input logic f, input logic e,
                               input logic b, input logic [31:0] bt,
                               input logic j, input logic [31:0] jt);
    stall         = s;
    flush         = f;
    exception     = e;
    branch_taken  = b;
    branch_target = bt;
    jump          = j;
    jump_target   = jt;
    @(posedge clk);
    #1;
  endtask

  task automatic checkState(input string tag, input logic [31:0] exp_pc,
                            input logic [31:0] exp_instr,
                            input logic [31:0] exp_pc4, input logic exp_valid,
                            input logic [31:0] exp_count);
    checkOutput({tag, ".pc"}, pc, exp_pc);
    checkOutput({tag, ".instr"}, if_id_instruction, exp_instr);
    checkOutput({tag, ".pc4"}, if_id_pc_plus4, exp_pc4);
    checkOutput({tag, ".valid"}, {31'h0, if_id_valid}, {31'h0, exp_valid});
    checkOutput({tag, ".count"}, fetch_count, exp_count);
  endtask

  initial begin
    error_count = 0;
    check_count = 0;
    for (int i = 0; i < 256; i++) mem[i] = word(i);
    reset_n = 1'b0;
    stall = 0; flush = 0; exception = 0; branch_taken = 0; jump = 0;
    branch_target = 0; jump_target = 0;

    repeat (2) @(posedge clk);
    #1;
    checkState("reset", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);
    checkOutput("reset.addr", {24'h0, imem_address}, 32'h0);
    reset_n = 1'b1;

    // sequential fetch
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkState("seq1", 32'h4, word(0), 32'h4, 1'b1, 32'd1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkState("seq2", 32'h8, word(1), 32'h8, 1'b1, 32'd2);

    // three-cycle stall at pc=8
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1, 0, 0, 0, 0, 0, 0);
      checkState("stall", 32'h8, word(1), 32'h8, 1'b1, 32'd2);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkState("unstall", 32'hC, word(2), 32'hC, 1'b1, 32'd3);

    // branch to 0x40
    applyStimulus(0, 0, 0, 1, 32'h40, 0, 0);
    checkState("branch", 32'h40, 32'h0, 32'h0, 1'b0, 32'd3);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkState("branch_tgt", 32'h44, word(16), 32'h44, 1'b1, 32'd4);

    // misaligned jump target, address aliasing
    applyStimulus(0, 0, 0, 0, 0, 1, 32'h0000_0403);
    checkState("jump", 32'h400, 32'h0, 32'h0, 1'b0, 32'd4);
    checkOutput("jump.addr", {24'h0, imem_address}, 32'h0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkState("jump_tgt", 32'h404, word(0), 32'h404, 1'b1, 32'd5);
    checkOutput("jump_tgt.addr", {24'h0, imem_address}, 32'h1);

    // exception wins over everything, including stall
    applyStimulus(1, 0, 1, 1, 32'h200, 1, 32'h300);
    checkState("exc_all", 32'h80, 32'h0, 32'h0, 1'b0, 32'd5);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkState("exc_tgt", 32'h84, word(32), 32'h84, 1'b1, 32'd6);

    // branch beats jump
    applyStimulus(0, 0, 0, 1, 32'h10, 1, 32'h30);
    checkState("br_vs_j", 32'h10, 32'h0, 32'h0, 1'b0, 32'd6);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkState("br_vs_j2", 32'h14, word(4), 32'h14, 1'b1, 32'd7);

    // flush alone: pc advances, bubble inserted
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    checkState("flush", 32'h18, 32'h0, 32'h0, 1'b0, 32'd7);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkState("flush2", 32'h1C, word(6), 32'h1C, 1'b1, 32'd8);

    // stall plus flush: pc holds, bubble, held pc re-fetched
    applyStimulus(1, 1, 0, 0, 0, 0, 0);
    checkState("stall_flush", 32'h1C, 32'h0, 32'h0, 1'b0, 32'd8);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkState("stall_flush2", 32'h20, word(7), 32'h20, 1'b1, 32'd9);

    // asynchronous reset between edges
    #3;
    reset_n = 1'b0;
    #1;
    checkState("async_rst", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);
    checkOutput("async_rst.addr", {24'h0, imem_address}, 32'h0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    checkOutput("post_rst.pc", pc, 32'h0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkState("post_rst", 32'h4, word(0), 32'h4, 1'b1, 32'd1);

    // 32-bit PC wrap
    applyStimulus(0, 0, 0, 0, 0, 1, 32'hFFFF_FFFC);
    checkState("wrap_jump", 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0, 32'd1);
    checkOutput("wrap.addr", {24'h0, imem_address}, 32'hFF);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkState("wrap", 32'h0, word(255), 32'h0, 1'b1, 32'd2);

    $display("Result: errors=%0d of %0d checks", error_count, check_count);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_stage.md
# instruction_fetch_stage

Pipeline IF stage for the MIPS core. It owns the program counter and drives the word address of the instruction memory. It captures the combinationally-read instruction into the IF/ID pipeline register. It applies stall, flush and control-flow redirects (exception, branch, jump) from later stages and counts delivered instructions.

## Interface
- `RAM_SIZE_BIT`, 8: width of the instruction-memory word address.
- `RESET_PC`, 32'h0000_0000: PC loaded on reset.
- `EXC_VECTOR`, 32'h0000_0080: PC loaded on exception.
- `clk`  in  1  single clock; all state updates on posedge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `stall`  in  1  hold PC and IF/ID contents (load-use hazard).
- `flush`  in  1  load a bubble into IF/ID.
- `exception`  in  1  redirect to `EXC_VECTOR`.
- `branch_taken`  in  1  redirect to `branch_target`.
- `branch_target`  in  32  branch destination byte address.
- `jump`  in  1  redirect to `jump_target`.
- `jump_target`  in  32  jump/jr destination byte address.
- `imem_address`  out  RAM_SIZE_BIT  = `pc[RAM_SIZE_BIT+1:2]`, combinational.
- `imem_read_data`  in  32  instruction word, combinational from memory.
- `pc`  out  32  current fetch PC.
- `if_id_instruction`  out  32  latched instruction.
- `if_id_pc_plus4`  out  32  latched PC+4 of that instruction.
- `if_id_valid`  out  1  1 = real instruction, 0 = bubble.
- `fetch_count`  out  32  number of valid instructions loaded into IF/ID.

## Operation
- Redirect priority: `exception` > `branch_taken` > `jump` > sequential (`pc+4`).
- Redirect targets are used with bits [1:0] forced to 0, so the PC is always word aligned.
- Next PC:
  - If any redirect is asserted, the PC loads the selected target. The redirect is honoured even when `stall`=1.
  - Otherwise, if `stall`=1, the PC holds.
  - Otherwise the PC loads `pc+4`, using 32-bit modulo arithmetic.
- IF/ID update, in priority order:
  - Any redirect or `flush`: load a bubble. `if_id_instruction`=32'h0000_0000 (sll $0 nop), `if_id_valid`=0, `if_id_pc_plus4`=0.
  - Else `stall`: hold all IF/ID fields.
  - Else load `imem_read_data`, `pc+4`, and `if_id_valid`=1.
- `fetch_count` increments by 1 on each cycle where IF/ID loads a valid instruction. It wraps at 2^32 with no saturation.
- PC bits above `RAM_SIZE_BIT+1` are ignored for addressing, so memory accesses alias (wrap). The full 32-bit PC is still kept and reported.
- Reset values:
  - `pc`=`RESET_PC`
  - `if_id_instruction`=0, `if_id_pc_plus4`=0, `if_id_valid`=0
  - `fetch_count`=0
  - `imem_address` follows `pc`.
- Reset asserted mid-operation clears all state immediately, with no clock needed. After release, the first fetch is from `RESET_PC`.

## Timing
- Memory read is combinational, so the instruction at `pc` is captured in IF/ID on the next posedge. PC-to-IF/ID latency is 1 cycle.
- A redirect asserted in cycle n gives:
  - `pc`=target in n+1, with IF/ID a bubble in n+1;
  - target instruction valid in IF/ID in n+2.
- `stall` held for k cycles freezes `pc` and IF/ID for exactly k cycles. Sequential fetch resumes on the first cycle with `stall`=0.
- `stall` and `flush` together: PC holds and IF/ID becomes a bubble. The held PC is re-fetched after the stall, so no instruction is lost.
- All inputs are sampled on the posedge. There are no combinational paths from control inputs to any output except `imem_address`, which depends on `pc`.

## Structure
- Shared package `cpu_defs` holds:
  - `NOP_INSTR` (32'h0);
  - the default `RESET_PC` and `EXC_VECTOR`;
  - the PC increment constant (4).
- One natural sub-module, `if_id_register`. It holds the instruction, pc_plus4 and valid fields, with stall/flush inputs and bubble insertion, and is reusable for the other pipeline registers.
- Next-PC selection and the counter stay in the top module.

## Test plan
- Reset, then release with no controls: `pc` goes 0,4,8,12. `if_id_instruction` equals memory words 0,1,2 one cycle behind. `fetch_count`=3 after 4 cycles.
- `stall`=1 for 3 cycles at `pc`=8: `pc` stays 8 and IF/ID stays unchanged for 3 cycles. Then `pc`=12 and `fetch_count` does not advance during the stall.
- `branch_taken`=1 with `branch_target`=32'h40 at `pc`=8:
  - next cycle `pc`=32'h40 and `if_id_valid`=0;
  - following cycle `if_id_instruction`=word 16, `if_id_pc_plus4`=32'h44.
- `exception`, `branch_taken`, `jump` and `stall` all asserted together: `pc`=`EXC_VECTOR`, IF/ID is a bubble.
- `jump_target`=32'h0000_0403 with `RAM_SIZE_BIT`=8: `pc`=32'h400 and `imem_address`=0 (aliasing).
- `reset_n` pulsed low between clock edges while `pc`=32'h20: outputs go to reset values immediately. After release `pc` is 0 and `fetch_count`=0.
